// File: rtl/id_pipe_stage.sv
// RV32I/RV64I integer decode stage: decodes OP-IMM/OP/LUI/AUIPC (plus the -32 forms on RV64)
// into register-file and ALU controls held in a one-entry valid/ready pipeline register.
module id_pipe_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int ILEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic              ra_en,
    output logic [REG_AW-1:0] ra_addr,
    output logic              rb_en,
    output logic [REG_AW-1:0] rb_addr,
    output logic              rd_en,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   imm,
    output logic              alu_asrc_pc,
    output logic              alu_bsrc,
    output logic [3:0]        alu_ctl,
    output logic              word_op,
    output logic              illegal
);

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              ra_en;
        logic [REG_AW-1:0] ra_addr;
        logic              rb_en;
        logic [REG_AW-1:0] rb_addr;
        logic              rd_en;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   imm;
        logic              asrc_pc;
        logic              bsrc;
        logic [3:0]        alu_ctl;
        logic              word_op;
        logic              illegal;
    } dec_t;

    dec_t d, q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_u, imm_sh;
    logic            is_shift, f7_ok, f3_word_ok, sh_hi_bad, legal, wide_sh;
    logic            accept;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));

    assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign f7_ok      = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign f3_word_ok = (funct3 == 3'b000) || is_shift;

    // Only RV64 non-word shifts get a 6-bit shamt; bit 30 is the SRAI selector and never checked.
    assign wide_sh   = (XLEN == 64) && (opcode == OPC_OP_IMM);
    assign sh_hi_bad = wide_sh ? |{in_inst[31], in_inst[29:26]} : |{in_inst[31], in_inst[29:25]};
    assign imm_sh    = wide_sh ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);

    always_comb begin
        d         = '0;
        legal     = 1'b0;
        d.pc      = in_pc;
        d.ra_addr = REG_AW'(in_inst[19:15]);
        d.rb_addr = REG_AW'(in_inst[24:20]);
        d.rd_addr = REG_AW'(in_inst[11:7]);
        unique case (opcode)
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                legal     = (opcode == OPC_OP_IMM) || ((XLEN == 64) && f3_word_ok);
                d.ra_en   = 1'b1;
                d.bsrc    = 1'b1;
                d.word_op = (opcode == OPC_OP_IMM_32);
                d.alu_ctl = {1'b0, funct3};
                d.imm     = imm_i;
                if (is_shift) begin
                    d.imm = imm_sh;
                    if (sh_hi_bad) legal = 1'b0;
                    if (funct3 == 3'b101) d.alu_ctl[3] = in_inst[30];
                end
            end
            OPC_OP, OPC_OP_32: begin
                legal     = f7_ok && ((opcode == OPC_OP) || ((XLEN == 64) && f3_word_ok));
                d.ra_en   = 1'b1;
                d.rb_en   = 1'b1;
                d.word_op = (opcode == OPC_OP_32);
                d.alu_ctl = {in_inst[30], funct3};
            end
            OPC_LUI: begin
                legal  = 1'b1;
                d.bsrc = 1'b1;
                d.imm  = imm_u;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                d.asrc_pc = 1'b1;
                d.bsrc    = 1'b1;
                d.imm     = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            d.ra_en   = 1'b0;
            d.rb_en   = 1'b0;
            d.asrc_pc = 1'b0;
            d.bsrc    = 1'b0;
            d.alu_ctl = '0;
            d.word_op = 1'b0;
            d.imm     = '0;
            d.illegal = 1'b1;
        end
        d.rd_en = legal && (d.rd_addr != '0);
    end

    assign in_ready = !out_valid || out_ready || flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         out_valid <= 1'b0;
        else if (flush)     out_valid <= 1'b0;
        else if (accept)    out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
    end

    // Payload is left alone on consume; it only matters while out_valid is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      q <= '0;
        else if (accept) q <= d;
    end

    assign out_pc      = q.pc;
    assign ra_en       = q.ra_en;
    assign ra_addr     = q.ra_addr;
    assign rb_en       = q.rb_en;
    assign rb_addr     = q.rb_addr;
    assign rd_en       = q.rd_en;
    assign rd_addr     = q.rd_addr;
    assign imm         = q.imm;
    assign alu_asrc_pc = q.asrc_pc;
    assign alu_bsrc    = q.bsrc;
    assign alu_ctl     = q.alu_ctl;
    assign word_op     = q.word_op;
    assign illegal     = q.illegal;

endmodule

// File: doc/id_pipe_stage.md
Name: id_pipe_stage

Overview:
- Registered RV32I/RV64I integer decode stage between IF and EX.
- Decodes OP-IMM, OP, LUI and AUIPC, plus OP-IMM-32 and OP-32 when XLEN=64.
- Produces sign-extended immediates, register-file controls and ALU controls behind a one-entry pipeline register.
- Uses valid/ready handshakes on both sides and supports flush.

Parameters:
- XLEN, 64, datapath width; legal values are 32 or 64.
- REG_AW, 5, register address width.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kills the held entry and any entry being accepted this cycle.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  ILEN  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  decoded entry is held.
- out_ready  in  1  EX consumes the entry.
- out_pc  out  XLEN  registered PC.
- ra_en  out  1  read rs1.
- ra_addr  out  REG_AW  rs1 address, inst[19:15].
- rb_en  out  1  read rs2.
- rb_addr  out  REG_AW  rs2 address, inst[24:20].
- rd_en  out  1  write rd.
- rd_addr  out  REG_AW  rd address, inst[11:7].
- imm  out  XLEN  sign-extended immediate.
- alu_asrc_pc  out  1  ALU operand A is the PC (AUIPC).
- alu_bsrc  out  1  ALU operand B is imm.
- alu_ctl  out  4  {alt, funct3}; alt=1 selects SUB or SRA.
- word_op  out  1  32-bit op whose result is sign-extended; only when XLEN=64.
- illegal  out  1  held instruction is unsupported.

Behaviour:
- Reset: all registered outputs are 0 while rst_n=0, including out_valid.
- in_ready = !out_valid | out_ready | flush. It is combinational and carries no in_valid dependency.
- Accept occurs when in_valid & in_ready. Decoded fields and in_pc are registered on that edge, so latency is 1 cycle.
- Next-state for out_valid:
  - flush: 0. A same-cycle accept is discarded.
  - else accept: 1.
  - else out_ready: 0.
  - else: hold.
- While out_valid & !out_ready, every output is held stable.
- Data fields are not cleared on consume. When out_valid=0 their values are don't-care.
- Decode by opcode:
  - 0010011: I-type; ra_en=1, alu_bsrc=1.
  - 0110011: R-type; ra_en=1, rb_en=1.
  - 0110111 (LUI): ra_en=0, alu_ctl=ADD. EX treats A as 0 when ra_en=0.
  - 0010111 (AUIPC): alu_asrc_pc=1, alu_ctl=ADD, alu_bsrc=1.
  - 0011011 and 0111011: same as the I-type and R-type rows with word_op=1, for XLEN=64 only. Only funct3 000, 001 and 101 are legal.
- alu_ctl = {alt, funct3}.
  - alt=inst[30] for R-type ADD/SUB and for SRL/SRA.
  - alt=inst[30] for SRLI/SRAI.
  - alt=0 for all other I-type encodings.
- Illegal conditions:
  - R-type funct7 other than 0000000, or other than 0100000 where funct3 is 000 or 101.
  - Shift-immediate upper bits nonzero other than bit 30: inst[31:26] for XLEN=64 non-word; inst[31:25] for XLEN=32 or word ops.
  - Any unlisted opcode.
- Illegal output: out_valid=1, illegal=1, all enables=0, alu_ctl=0, word_op=0.
- Immediates:
  - I-type: inst[31:20] sign-extended to XLEN.
  - Shift: shamt zero-extended. shamt is inst[25:20] for XLEN=64 non-word, inst[24:20] otherwise.
  - U-type: {inst[31:12], 12'b0} sign-extended to XLEN.
  - R-type: imm=0.
- rd_en = legal & (rd_addr != 0).
- If rst_n asserts mid-transfer, the entry is lost and out_valid=0 immediately, asynchronously.

Test Plan:
- Reset: rst_n low with in_valid=1 -> out_valid=0, in_ready=1 and all outputs 0. After release, accept occurs on the first edge.
- Decode ADDI/LUI/AUIPC:
  - ADDI x5,x0,-1 (0xFFF00293) at XLEN=64 -> next cycle imm=0xFFFF_FFFF_FFFF_FFFF, rd_en=1, rd_addr=5, alu_bsrc=1, alu_ctl=0000.
  - LUI x1,0x80000 -> imm=0xFFFF_FFFF_8000_0000.
  - AUIPC -> alu_asrc_pc=1.
- Backpressure:
  - Stream 3 instructions with out_ready=0 for 4 cycles -> first held stable, in_ready=0, no loss or duplication.
  - Release -> all 3 emerge in order.
  - out_ready=1 continuously -> one instruction per cycle.
- Flush: flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, that input is consumed and dropped, no output for either.
- Illegal/edge encodings:
  - SUB x3,x1,x2 -> alu_ctl=1000, rb_en=1.
  - SRAI x4,x4,63 at XLEN=64 -> alu_ctl=1101, imm=63.
  - Same SRAI at XLEN=32 -> illegal=1.
  - ADDIW at XLEN=32 -> illegal=1.
  - ADDI x0,x0,0 -> rd_en=0.
- Word ops at XLEN=64: ADDW -> word_op=1, alu_ctl=0000. SLLIW with inst[25]=1 -> illegal=1.
